// File: rtl/bp_me_cce_flit_tx.sv
// Serializes one coherence/memory message into a wormhole header flit plus 0..N data flits.
// Optional BP_ME_FLIT_TX_ID_CHECK_EN: drop messages whose cce_id is out of range and raise sticky err_o.
//
// state    | meaning
// S_READY  | idle, accepting a message (ready_and_o=1)
// S_HEADER | presenting header flit built from registered message
// S_DATA   | presenting data flit r_cnt of r_len
module bp_me_cce_flit_tx #(
    parameter int paddr_width_p  = 40,
    parameter int cce_id_width_p = 6,
    parameter int num_cce_p      = 16,
    parameter int x_dim_p        = 4,
    parameter int cord_x_width_p = 4,
    parameter int cord_y_width_p = 3,
    parameter int len_width_p    = 4,
    parameter int flit_width_p   = 64,
    parameter int data_width_p   = 512
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      v_i,
    output logic                      ready_and_o,
    input  logic [paddr_width_p-1:0]  paddr_i,
    input  logic [2:0]                size_i,
    input  logic                      has_data_i,
    input  logic [data_width_p-1:0]   data_i,
    input  logic [cce_id_width_p-1:0] cce_id_i,
    output logic                      link_v_o,
    output logic [flit_width_p-1:0]   link_data_o,
    input  logic                      link_ready_and_i,
    output logic                      err_o
);

    localparam int MAX_FLITS = data_width_p / flit_width_p;
    localparam int IDX_W     = (MAX_FLITS > 1) ? $clog2(MAX_FLITS) : 1;
    localparam int CORD_W    = cord_x_width_p + cord_y_width_p;
    localparam int CID_W     = 2;
    localparam int HDR_W     = CORD_W + CID_W + len_width_p + paddr_width_p + 3;
    localparam int X_SHIFT   = $clog2(x_dim_p);

    generate
        if (HDR_W > flit_width_p || (data_width_p % flit_width_p) != 0
            || num_cce_p > (1 << cce_id_width_p)) begin : g_cfg_check
            $error("bp_me_cce_flit_tx: header does not fit in a flit or bad parameters");
        end
    endgenerate

    typedef enum logic [1:0] {S_READY, S_HEADER, S_DATA} state_e;

    state_e                                r_state, w_state_next;
    logic [len_width_p-1:0]                r_len, r_cnt, w_cnt_next, w_len;
    logic [paddr_width_p-1:0]              r_paddr;
    logic [2:0]                            r_size;
    logic [CORD_W-1:0]                     r_cord;
    logic [MAX_FLITS-1:0][flit_width_p-1:0] r_data;
    logic [CORD_W-1:0]                     w_cord;
    logic [flit_width_p-1:0]               w_hdr;
    logic                                  w_accept, w_bad_id;
    int                                    w_flits;

    assign w_cord = {cord_y_width_p'(cce_id_i >> X_SHIFT),
                     cord_x_width_p'(cce_id_i[X_SHIFT-1:0])};
    assign w_hdr  = flit_width_p'({r_size, r_paddr, r_len, {CID_W{1'b0}}, r_cord});
    assign w_accept = v_i && (r_state == S_READY);

    // payload bits rounded up to whole flits, at least one, at most a full data_i
    always_comb begin
        w_flits = (int'(32'd8 << size_i) + flit_width_p - 1) / flit_width_p;
        if (w_flits < 1)         w_flits = 1;
        if (w_flits > MAX_FLITS) w_flits = MAX_FLITS;
        w_len = has_data_i ? len_width_p'(w_flits) : '0;
    end

`ifdef BP_ME_FLIT_TX_ID_CHECK_EN
    localparam logic [cce_id_width_p:0] NUM_CCE_L = (cce_id_width_p + 1)'(num_cce_p);
    logic r_err;

    assign w_bad_id = ({1'b0, cce_id_i} >= NUM_CCE_L);
    assign err_o    = r_err;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)                   r_err <= 1'b0;
        else if (w_accept && w_bad_id) r_err <= 1'b1;
    end
`else
    assign w_bad_id = 1'b0;
    assign err_o    = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        ready_and_o  = 1'b0;
        link_v_o     = 1'b0;
        link_data_o  = '0;
        case (r_state)
            S_READY: begin
                ready_and_o = 1'b1;
                if (v_i && !w_bad_id) w_state_next = S_HEADER;
            end
            S_HEADER: begin
                link_v_o    = 1'b1;
                link_data_o = w_hdr;
                if (link_ready_and_i) begin
                    w_cnt_next   = '0;
                    w_state_next = (r_len == '0) ? S_READY : S_DATA;
                end
            end
            S_DATA: begin
                link_v_o    = 1'b1;
                link_data_o = r_data[r_cnt[IDX_W-1:0]];
                if (link_ready_and_i) begin
                    if (r_cnt == r_len - 1'b1) w_state_next = S_READY;
                    else                       w_cnt_next   = r_cnt + 1'b1;
                end
            end
            default: w_state_next = S_READY;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_READY;
            r_cnt   <= '0;
            r_len   <= '0;
            r_paddr <= '0;
            r_size  <= '0;
            r_cord  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_len   <= w_len;
                r_paddr <= paddr_i;
                r_size  <= size_i;
                r_cord  <= w_cord;
                r_data  <= data_i;
            end
        end
    end

endmodule

// File: tb/tb_bp_me_cce_flit_tx.sv
// Scoreboard bench for bp_me_cce_flit_tx: expected flits queued at acceptance, monitor pops on link handshakes.
module tb_bp_me_cce_flit_tx;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         v_i;
    logic         ready_and_o;
    logic [39:0]  paddr_i;
    logic [2:0]   size_i;
    logic         has_data_i;
    logic [511:0] data_i;
    logic [5:0]   cce_id_i;
    logic         link_v_o;
    logic [63:0]  link_data_o;
    logic         link_ready_and_i;
    logic         err_o;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    int          pop_idx = 0;
    int          rdy_mode = 0;
    int          stall_target = -1;
    int          stall_left = 0;

    bp_me_cce_flit_tx dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .v_i              (v_i),
        .ready_and_o      (ready_and_o),
        .paddr_i          (paddr_i),
        .size_i           (size_i),
        .has_data_i       (has_data_i),
        .data_i           (data_i),
        .cce_id_i         (cce_id_i),
        .link_v_o         (link_v_o),
        .link_data_o      (link_data_o),
        .link_ready_and_i (link_ready_and_i),
        .err_o            (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int exp_len(input bit hd, input int sz);
        int f;
        if (!hd) return 0;
        f = ((1 << sz) * 8 + 63) / 64;
        if (f < 1) f = 1;
        if (f > 8) f = 8;
        return f;
    endfunction

    function automatic logic [63:0] mk_hdr(input logic [39:0] pa, input int sz, input int len, input int id);
        logic [63:0] h;
        int y, x;
        y = id / 4;
        x = id % 4;
        h        = '0;
        h[6:0]   = 7'(y * 16 + x);
        h[12:9]  = 4'(len);
        h[52:13] = pa;
        h[55:53] = 3'(sz);
        return h;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [39:0] rnd40();
        return {8'($urandom), 32'($urandom)};
    endfunction

    // downstream ready: random, forced high, or a 3-cycle stall when flit stall_target is presented
    initial begin
        link_ready_and_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (stall_left > 0) begin
                link_ready_and_i = 1'b0;
                stall_left--;
            end else if (pop_idx == stall_target) begin
                link_ready_and_i = 1'b0;
                stall_left = 2;
                stall_target = -1;
            end else if (rdy_mode == 1) begin
                link_ready_and_i = 1'b1;
            end else begin
                link_ready_and_i = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin : monitor
        logic        stalled;
        logic [63:0] held;
        logic [63:0] e;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk_i);
            if (reset_i) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    checks++;
                    if (!link_v_o || link_data_o !== held) begin
                        errors++;
                        $display("FAIL stall_hold: got v=%0b data=%0h expected v=1 data=%0h", link_v_o, link_data_o, held);
                    end
                end
                if (link_v_o && link_ready_and_i) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_flit: got %0h expected none", link_data_o);
                    end else begin
                        e = exp_q.pop_front();
                        if (link_data_o !== e) begin
                            errors++;
                            $display("FAIL flit %0d: got %0h expected %0h", pop_idx, link_data_o, e);
                        end
                    end
                    pop_idx++;
                    stalled = 1'b0;
                end else if (link_v_o) begin
                    stalled = 1'b1;
                    held    = link_data_o;
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    // called at posedge+1; returns at the negedge after the accepting clock edge
    task automatic send(input logic [39:0] pa, input logic [2:0] sz, input bit hd,
                        input logic [511:0] d, input logic [5:0] id, input bit drop);
        int n;
        int len;
        paddr_i    = pa;
        size_i     = sz;
        has_data_i = hd;
        data_i     = d;
        cce_id_i   = id;
        v_i        = 1'b1;
        n = 0;
        @(negedge clk_i);
        while (!ready_and_o && n < 200) begin
            n++;
            @(negedge clk_i);
        end
        if (!ready_and_o) begin
            chk("accept_timeout", 64'(ready_and_o), 64'd1);
            v_i = 1'b0;
            return;
        end
        if (!drop) begin
            len = exp_len(hd, int'(sz));
            exp_q.push_back(mk_hdr(pa, int'(sz), len, int'(id)));
            for (int k = 0; k < len; k++) exp_q.push_back(d[k*64 +: 64]);
        end
        @(posedge clk_i);
        #1;
        v_i        = 1'b0;
        paddr_i    = rnd40();
        size_i     = 3'($urandom);
        has_data_i = 1'($urandom);
        cce_id_i   = 6'($urandom);
        @(negedge clk_i);
        if (drop) begin
            chk("drop_ready", 64'(ready_and_o), 64'd1);
            chk("drop_no_flit", 64'(link_v_o), 64'd0);
            chk("err_set", 64'(err_o), 64'd1);
        end else begin
            chk("hdr_latency_v", 64'(link_v_o), 64'd1);
            chk("busy_not_ready", 64'(ready_and_o), 64'd0);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        reset_i    = 1'b1;
        v_i        = 1'b0;
        paddr_i    = '0;
        size_i     = '0;
        has_data_i = 1'b0;
        data_i     = '0;
        cce_id_i   = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("rst_ready", 64'(ready_and_o), 64'd1);
        chk("rst_link_v", 64'(link_v_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        @(posedge clk_i);
        #1;

        // header-only message, link always ready
        rdy_mode = 1;
        base = pop_idx;
        send(40'h00_8000_1040, 3'd3, 1'b0, '0, 6'd5, 1'b0);
        chk("d1_hdr_const", link_data_o, 64'h0060_1000_0208_0011);
        @(negedge clk_i);
        chk("d1_ready_after", 64'(ready_and_o), 64'd1);
        chk("d1_idle", 64'(link_v_o), 64'd0);
        chk("d1_nflits", 64'(pop_idx - base), 64'd1);
        @(posedge clk_i);
        #1;

        // full 64-byte message with a stall on data flit 4
        rdy_mode = 0;
        base = pop_idx;
        stall_target = base + 5;
        send(rnd40(), 3'd6, 1'b1, rnd512(), 6'd2, 1'b0);
        wait_drain();
        chk("d2_nflits", 64'(pop_idx - base), 64'd9);

        base = pop_idx;
        send(rnd40(), 3'd2, 1'b1, rnd512(), 6'd7, 1'b0);
        wait_drain();
        chk("d3_nflits", 64'(pop_idx - base), 64'd2);

        // async reset while data flit 3 is on the link
        base = pop_idx;
        send(rnd40(), 3'd6, 1'b1, rnd512(), 6'd9, 1'b0);
        n = 0;
        while (pop_idx != base + 4 && n < 500) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        chk("rst_mid_reach", 64'(pop_idx - base), 64'd4);
        #1 reset_i = 1'b1;
        #1 chk("rst_mid_async_v", 64'(link_v_o), 64'd0);
        exp_q.delete();
        @(negedge clk_i);
        #2 reset_i = 1'b0;
        @(posedge clk_i);
        #1;
        base = pop_idx;
        send(rnd40(), 3'd4, 1'b1, rnd512(), 6'd3, 1'b0);
        wait_drain();
        chk("post_rst_nflits", 64'(pop_idx - base), 64'd3);

        repeat (30) begin
            send(rnd40(), 3'($urandom_range(0, 6)), 1'($urandom), rnd512(),
                 6'($urandom_range(0, 15)), 1'b0);
            if ($urandom_range(0, 3) == 0) wait_drain();
        end
        wait_drain();

`ifdef BP_ME_FLIT_TX_ID_CHECK_EN
        base = pop_idx;
        send(rnd40(), 3'd6, 1'b1, rnd512(), 6'd16, 1'b1);
        repeat (5) @(negedge clk_i);
        chk("bad_id_no_flits", 64'(pop_idx - base), 64'd0);
        @(posedge clk_i);
        #1;
        send(rnd40(), 3'd5, 1'b1, rnd512(), 6'd15, 1'b0);
        wait_drain();
        chk("after_bad_nflits", 64'(pop_idx - base), 64'd5);
        chk("err_sticky", 64'(err_o), 64'd1);
`else
        chk("err_tied_low", 64'(err_o), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
